// File: rtl/regfile_seq_pkg.sv
// Shared opcode/state encodings and default widths for the register-file
// operation sequencer.
package regfile_seq_pkg;

  localparam int unsigned DATA_W_DEF = 20;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_LDI = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational ALU: opcode plus captured operands/immediate -> result,
// carry/borrow and zero flag.
module regfile_seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o
);

  logic [DATA_W:0]   sum;
  logic [4:0]        shamt;
  logic              sh_sat;

  assign shamt  = b_i[4:0];
  // Shift amounts at or beyond the data width flush the result to zero.
  assign sh_sat = {27'd0, shamt} >= DATA_W;

  always_comb begin
    sum      = '0;
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      OP_SUB: begin
        result_o = a_i - b_i;
        carry_o  = a_i < b_i;
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SHL:  result_o = sh_sat ? '0 : (a_i << shamt);
      OP_SHR:  result_o = sh_sat ? '0 : (a_i >> shamt);
      OP_LDI:  result_o = imm_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/regfile_op_sequencer.sv
// Command-driven initiator for the register file: accepts one ALU command,
// reads both operands, computes and writes the result back (IDLE/READ/EXEC/WB).
module regfile_op_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic [2:0]        cmdOp,
  input  logic [ADDR_W-1:0] cmdDst,
  input  logic [ADDR_W-1:0] cmdSrcA,
  input  logic [ADDR_W-1:0] cmdSrcB,
  input  logic [DATA_W-1:0] cmdImm,
  output logic [ADDR_W-1:0] rfRdAddrA,
  input  logic [DATA_W-1:0] rfRdDataA,
  output logic [ADDR_W-1:0] rfRdAddrB,
  input  logic [DATA_W-1:0] rfRdDataB,
  output logic              rfWrite,
  output logic [ADDR_W-1:0] rfWrAddr,
  output logic [DATA_W-1:0] rfWrData,
  output logic              doneValid,
  output logic [DATA_W-1:0] doneData,
  output logic              flagCarry,
  output logic              flagZero,
  output logic [CNT_W-1:0]  opCount
);

  state_e            state_q, state_d;
  logic              accept;

  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] opA_q, opA_d, opB_q, opB_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              carry_q, carry_d, zero_q, zero_d;

  logic              cmdReady_q, cmdReady_d;
  logic [ADDR_W-1:0] rdA_q, rdA_d, rdB_q, rdB_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [DATA_W-1:0] wrData_q, wrData_d;
  logic              doneV_q, doneV_d;
  logic [DATA_W-1:0] doneD_q, doneD_d;
  logic              fC_q, fC_d, fZ_q, fZ_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] alu_res;
  logic              alu_carry, alu_zero;

  assign accept = cmdValid && cmdReady_q;

  regfile_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i    (op_q),
    .a_i     (opA_q),
    .b_i     (opB_q),
    .imm_i   (imm_q),
    .result_o(alu_res),
    .carry_o (alu_carry),
    .zero_o  (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      dst_q      <= '0;
      imm_q      <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      cmdReady_q <= 1'b1;
      rdA_q      <= '0;
      rdB_q      <= '0;
      wr_q       <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      doneV_q    <= 1'b0;
      doneD_q    <= '0;
      fC_q       <= 1'b0;
      fZ_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      imm_q      <= imm_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      cmdReady_q <= cmdReady_d;
      rdA_q      <= rdA_d;
      rdB_q      <= rdB_d;
      wr_q       <= wr_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
      doneV_q    <= doneV_d;
      doneD_q    <= doneD_d;
      fC_q       <= fC_d;
      fZ_q       <= fZ_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write-port outputs are registered on the WB edge, so they are visible in
  // the cycle after WB, together with cmdReady re-rising.
  always_comb begin
    op_d       = op_q;
    dst_d      = dst_q;
    imm_d      = imm_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    res_d      = res_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    cmdReady_d = cmdReady_q;
    rdA_d      = rdA_q;
    rdB_d      = rdB_q;
    wr_d       = 1'b0;
    wrAddr_d   = wrAddr_q;
    wrData_d   = wrData_q;
    doneV_d    = 1'b0;
    doneD_d    = doneD_q;
    fC_d       = fC_q;
    fZ_d       = fZ_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d       = cmdOp;
          dst_d      = cmdDst;
          imm_d      = cmdImm;
          rdA_d      = cmdSrcA;
          rdB_d      = cmdSrcB;
          cmdReady_d = 1'b0;
        end
      end
      S_READ: begin
        opA_d = rfRdDataA;
        opB_d = rfRdDataB;
      end
      S_EXEC: begin
        res_d   = alu_res;
        carry_d = alu_carry;
        zero_d  = alu_zero;
      end
      S_WB: begin
        wr_d       = 1'b1;
        wrAddr_d   = dst_q;
        wrData_d   = res_q;
        doneV_d    = 1'b1;
        doneD_d    = res_q;
        fC_d       = carry_q;
        fZ_d       = zero_q;
        cnt_d      = cnt_q + 1'b1;
        cmdReady_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign cmdReady  = cmdReady_q;
  assign rfRdAddrA = rdA_q;
  assign rfRdAddrB = rdB_q;
  assign rfWrite   = wr_q;
  assign rfWrAddr  = wrAddr_q;
  assign rfWrData  = wrData_q;
  assign doneValid = doneV_q;
  assign doneData  = doneD_q;
  assign flagCarry = fC_q;
  assign flagZero  = fZ_q;
  assign opCount   = cnt_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: behavioural register-file model plus an
// in-order command model checked every cycle, directed cases then random.
module tb_regfile_op_sequencer;

  localparam int unsigned DW = 20;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmdValid = 1'b0;
  logic          cmdReady;
  logic [2:0]    cmdOp = '0;
  logic [AW-1:0] cmdDst = '0, cmdSrcA = '0, cmdSrcB = '0;
  logic [DW-1:0] cmdImm = '0;
  logic [AW-1:0] rfRdAddrA, rfRdAddrB, rfWrAddr;
  logic [DW-1:0] rfRdDataA, rfRdDataB, rfWrData, doneData;
  logic          rfWrite, doneValid, flagCarry, flagZero;
  logic [CW-1:0] opCount;

  // literal expectations travel alongside each command
  logic          t_lh = 1'b0, t_lc = 1'b0, t_lz = 1'b0, t_lg = 1'b0;
  logic [DW-1:0] t_ld = '0;
  int            t_lcnt = -1;

  always #5 clk = ~clk;

  regfile_op_sequencer #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
    .cmdDst(cmdDst), .cmdSrcA(cmdSrcA), .cmdSrcB(cmdSrcB), .cmdImm(cmdImm),
    .rfRdAddrA(rfRdAddrA), .rfRdDataA(rfRdDataA),
    .rfRdAddrB(rfRdAddrB), .rfRdDataB(rfRdDataB),
    .rfWrite(rfWrite), .rfWrAddr(rfWrAddr), .rfWrData(rfWrData),
    .doneValid(doneValid), .doneData(doneData),
    .flagCarry(flagCarry), .flagZero(flagZero), .opCount(opCount)
  );

  // register file attached to the DUT ports
  logic [DW-1:0] rf [16];
  assign rfRdDataA = rf[rfRdAddrA];
  assign rfRdDataB = rf[rfRdAddrB];
  always @(posedge clk) if (rfWrite) rf[rfWrAddr] <= rfWrData;

  typedef struct {
    int unsigned   due;
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
    logic          carry, zero;
    logic          lh, lc, lz;
    logic [DW-1:0] ld;
    int            lcnt;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mdl_rf [16];
  int unsigned   cyc = 0;
  int unsigned   last_acc = 0;
  int            n_cmp = 0, n_bad = 0;
  logic          e_c = 1'b0, e_z = 1'b0;
  logic [DW-1:0] e_dd = '0, e_wd = '0;
  logic [AW-1:0] e_wa = '0, e_ra = '0, e_rb = '0;
  logic [CW-1:0] e_cnt = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void model_op(input logic [2:0] op, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b, input logic [DW-1:0] imm,
                                   output logic [DW-1:0] r, output logic c);
    longint unsigned la, lb, s;
    int unsigned sh;
    la = 64'(a); lb = 64'(b); sh = {27'd0, b[4:0]};
    c = 1'b0;
    case (op)
      3'd0: begin s = la + lb; r = s[DW-1:0]; c = s[DW]; end
      3'd1: begin s = la - lb; r = s[DW-1:0]; c = (la < lb); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sh >= DW) ? '0 : DW'(la << sh);
      3'd6: r = (sh >= DW) ? '0 : DW'(la >> sh);
      default: r = imm;
    endcase
  endfunction

  always begin
    exp_t e;
    logic ew;
    @(posedge clk);
    cyc++;
    if (rst_n && cmdValid && cmdReady) begin
      model_op(cmdOp, mdl_rf[cmdSrcA], mdl_rf[cmdSrcB], cmdImm, e.data, e.carry);
      e.zero = (e.data == '0);
      e.due = cyc + 3; e.dst = cmdDst;
      e.lh = t_lh; e.ld = t_ld; e.lc = t_lc; e.lz = t_lz; e.lcnt = t_lcnt;
      if (t_lg) check("accept_spacing", cyc - last_acc, 4);
      last_acc = cyc;
      e_ra = cmdSrcA; e_rb = cmdSrcB;
      q.push_back(e);
    end
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      e_c = 0; e_z = 0; e_dd = '0; e_wd = '0; e_wa = '0; e_ra = '0; e_rb = '0; e_cnt = '0;
      check("rst_cmdReady", cmdReady, 1);
      check("rst_rfWrite", rfWrite, 0);
      check("rst_doneValid", doneValid, 0);
      check("rst_rdAddr", {rfRdAddrA, rfRdAddrB}, 0);
      check("rst_wrAddr", rfWrAddr, 0);
      check("rst_wrData", rfWrData, 0);
      check("rst_doneData", doneData, 0);
      check("rst_flags", {flagCarry, flagZero}, 0);
      check("rst_opCount", opCount, 0);
    end else begin
      ew = (q.size() != 0) && (q[0].due == cyc);
      check("rfWrite", rfWrite, ew);
      check("doneValid", doneValid, ew);
      check("cmdReady", cmdReady, (q.size() == 0) || ew);
      if (ew) begin
        e = q.pop_front();
        e_c = e.carry; e_z = e.zero; e_dd = e.data; e_wd = e.data; e_wa = e.dst;
        e_cnt = e_cnt + 1'b1;
        mdl_rf[e.dst] = e.data;
        if (e.lh) begin
          check("lit_model_data", e.data, e.ld);
          check("lit_rfWrData", rfWrData, e.ld);
          check("lit_flags", {flagCarry, flagZero}, {e.lc, e.lz});
          if (e.lcnt >= 0) check("lit_opCount", opCount, e.lcnt);
        end
      end
      check("rfWrAddr", rfWrAddr, e_wa);
      check("rfWrData", rfWrData, e_wd);
      check("doneData", doneData, e_dd);
      check("flagCarry", flagCarry, e_c);
      check("flagZero", flagZero, e_z);
      check("opCount", opCount, e_cnt);
      check("rfRdAddrA", rfRdAddrA, e_ra);
      check("rfRdAddrB", rfRdAddrB, e_rb);
    end
  end

  task automatic send(input logic [2:0] op, input logic [AW-1:0] d, input logic [AW-1:0] a,
                      input logic [AW-1:0] b, input logic [DW-1:0] imm, input logic hold,
                      input logic lh, input logic [DW-1:0] ld, input logic lc,
                      input logic lz, input int lcnt, input logic lg);
    int n;
    cmdOp = op; cmdDst = d; cmdSrcA = a; cmdSrcB = b; cmdImm = imm; cmdValid = 1'b1;
    t_lh = lh; t_ld = ld; t_lc = lc; t_lz = lz; t_lcnt = lcnt; t_lg = lg;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmdReady) break;
      n++;
      if (n > 40) begin
        $display("FAIL cmdReady_timeout: got 0 expected 1 (cycle %0d)", cyc);
        $fatal(1, "command never accepted");
      end
    end
    @(posedge clk);
    #1;
    if (!hold) cmdValid = 1'b0;
    t_lh = 1'b0; t_lg = 1'b0; t_lcnt = -1;
  endtask

  task automatic ldi(input logic [AW-1:0] d, input logic [DW-1:0] v);
    send(3'd7, d, '0, '0, v, 1'b0, 1'b0, '0, 1'b0, 1'b0, -1, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    send(3'd7, 4'd1, 0, 0, 20'h00005, 0, 1, 20'h00005, 0, 0, 1, 0);
    ldi(4'd2, 20'h00003);
    send(3'd0, 4'd3, 4'd1, 4'd2, 0, 0, 1, 20'h00008, 0, 0, 3, 0);
    ldi(4'd4, 20'hFFFFF);
    send(3'd0, 4'd5, 4'd4, 4'd1, 0, 0, 1, 20'h00004, 1, 0, -1, 0);
    send(3'd1, 4'd6, 4'd2, 4'd1, 0, 0, 1, 20'hFFFFE, 1, 0, -1, 0);
    send(3'd5, 4'd7, 4'd1, 4'd2, 0, 0, 1, 20'h00028, 0, 0, -1, 0);
    ldi(4'd8, 20'd25);
    send(3'd5, 4'd12, 4'd1, 4'd8, 0, 0, 1, 20'h00000, 0, 1, -1, 0);

    // cmdValid held across three queued commands
    send(3'd0, 4'd13, 4'd1, 4'd2, 0, 1, 1, 20'h00008, 0, 0, -1, 0);
    send(3'd3, 4'd14, 4'd5, 4'd7, 0, 1, 1, 20'h0002C, 0, 0, -1, 1);
    send(3'd6, 4'd15, 4'd4, 4'd2, 0, 0, 1, 20'h1FFFF, 0, 0, -1, 1);

    send(3'd4, 4'd1, 4'd1, 4'd1, 0, 0, 1, 20'h00000, 0, 1, -1, 0);
    send(3'd0, 4'd9, 4'd1, 4'd2, 0, 0, 1, 20'h00003, 0, 0, -1, 0);
    ldi(4'd0, 20'h00000);
    ldi(4'd10, 20'h12345);
    ldi(4'd11, 20'h00000);

    // reset while the ADD r10 is in EXEC
    send(3'd0, 4'd10, 4'd1, 4'd2, 0, 0, 0, '0, 0, 0, -1, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    send(3'd0, 4'd11, 4'd10, 4'd0, 0, 0, 1, 20'h12345, 0, 0, 1, 0);

    for (int unsigned i = 0; i < 300; i++) begin
      logic [DW-1:0] imm;
      logic hold;
      imm  = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 40)) : DW'($urandom);
      hold = ($urandom_range(0, 3) == 0);
      send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), imm, hold, 0, '0, 0, 0, -1, 0);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    cmdValid = 1'b0;
    repeat (8) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
